// File: rtl/dnn_infer_seq.sv
// Sequencer/argmax unit for the fix7 ReLU inference engine: clears and launches
// the engine, scans its scores and reports the argmax. Optional watchdog: DNN_SEQ_TIMEOUT_EN.
module dnn_infer_seq #(
    parameter int DATA_WIDTH     = 7,
    parameter int NUM_CLASSES    = 10,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req,
    output logic                  busy,
    output logic                  eng_reset,
    output logic                  eng_start,
    input  logic                  eng_done,
    output logic [3:0]            out_idx,
    input  logic [DATA_WIDTH-1:0] score,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [3:0]            res_class,
    output logic [DATA_WIDTH-1:0] res_score,
    output logic                  res_err
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CLEAR     = 3'd1,
        LAUNCH    = 3'd2,
        WAIT_DONE = 3'd3,
        SCAN      = 3'd4,
        REPORT    = 3'd5
    } state_t;

    state_t                state_r;
    logic [DATA_WIDTH-1:0] best_score_r;
    logic [3:0]            best_idx_r;
    logic                  take_s;
    logic                  last_s;
    logic [DATA_WIDTH-1:0] new_score_s;
    logic [3:0]            new_idx_s;
`ifdef DNN_SEQ_TIMEOUT_EN
    logic [15:0]           wait_cnt_r;
`endif

    // Running argmax: first class always taken, later ones only on a strictly greater signed score.
    always_comb begin
        take_s      = (out_idx == 4'd0) || ($signed(score) > $signed(best_score_r));
        last_s      = (out_idx == 4'(NUM_CLASSES - 1));
        new_score_s = best_score_r;
        new_idx_s   = best_idx_r;
        if (take_s) begin
            new_score_s = score;
            new_idx_s   = out_idx;
        end else begin
            new_score_s = best_score_r;
            new_idx_s   = best_idx_r;
        end
    end

    // Sequencer FSM with all outputs registered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= IDLE;
            busy         <= 1'b0;
            eng_reset    <= 1'b0;
            eng_start    <= 1'b0;
            out_idx      <= 4'd0;
            res_valid    <= 1'b0;
            res_class    <= 4'd0;
            res_score    <= '0;
            res_err      <= 1'b0;
            best_score_r <= '0;
            best_idx_r   <= 4'd0;
`ifdef DNN_SEQ_TIMEOUT_EN
            wait_cnt_r   <= 16'd0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    if (req) begin
                        state_r   <= CLEAR;
                        busy      <= 1'b1;
                        eng_reset <= 1'b1;
                    end else begin
                        state_r   <= IDLE;
                    end
                end
                CLEAR: begin
                    eng_reset <= 1'b0;
                    eng_start <= 1'b1;
                    state_r   <= LAUNCH;
                end
                LAUNCH: begin
                    eng_start <= 1'b0;
                    state_r   <= WAIT_DONE;
`ifdef DNN_SEQ_TIMEOUT_EN
                    wait_cnt_r <= 16'd0;
`endif
                end
                WAIT_DONE: begin
                    if (eng_done) begin
                        state_r <= SCAN;
                        out_idx <= 4'd0;
`ifdef DNN_SEQ_TIMEOUT_EN
                    end else if (wait_cnt_r == 16'(TIMEOUT_CYCLES - 1)) begin
                        state_r   <= REPORT;
                        res_valid <= 1'b1;
                        res_err   <= 1'b1;
                        res_class <= 4'd0;
                        res_score <= '0;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + 16'd1;
                    end
`else
                    end else begin
                        state_r <= WAIT_DONE;
                    end
`endif
                end
                SCAN: begin
                    best_score_r <= new_score_s;
                    best_idx_r   <= new_idx_s;
                    if (last_s) begin
                        state_r   <= REPORT;
                        out_idx   <= 4'd0;
                        res_valid <= 1'b1;
                        res_class <= new_idx_s;
                        res_score <= new_score_s;
                    end else begin
                        out_idx   <= out_idx + 4'd1;
                    end
                end
                REPORT: begin
                    if (res_ready) begin
                        state_r   <= IDLE;
                        busy      <= 1'b0;
                        res_valid <= 1'b0;
                        res_err   <= 1'b0;
                    end else begin
                        state_r   <= REPORT;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    busy      <= 1'b0;
                    eng_reset <= 1'b0;
                    eng_start <= 1'b0;
                    out_idx   <= 4'd0;
                    res_valid <= 1'b0;
                    res_err   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dnn_infer_seq.sv
// Scoreboard bench for dnn_infer_seq with a behavioural engine model
// (programmable done latency, score table indexed by out_idx).
module tb_dnn_infer_seq;

`ifdef DNN_SEQ_TIMEOUT_EN
    localparam int TMO = 50;
`else
    localparam int TMO = 65535;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       req = 1'b0;
    logic       busy, eng_reset, eng_start;
    logic       eng_done = 1'b0;
    logic [3:0] out_idx;
    logic [6:0] score;
    logic       res_valid;
    logic       res_ready = 1'b0;
    logic [3:0] res_class;
    logic [6:0] res_score;
    logic       res_err;

    dnn_infer_seq #(.DATA_WIDTH(7), .NUM_CLASSES(10), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst), .req(req), .busy(busy),
        .eng_reset(eng_reset), .eng_start(eng_start), .eng_done(eng_done),
        .out_idx(out_idx), .score(score), .res_valid(res_valid),
        .res_ready(res_ready), .res_class(res_class), .res_score(res_score),
        .res_err(res_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cls;
        int sc;
        int err;
    } exp_t;

    exp_t exp_q[$];
    int   pass_cnt  = 0;
    int   total_cnt = 0;
    int   scores[16];
    int   done_lat  = 0;
    int   lat_cnt   = 0;
    logic counting  = 1'b0;

    assign score = 7'(scores[out_idx]);

    // Engine model: eng_done rises done_lat cycles after the cycle following eng_start.
    always @(posedge clk) begin
        if (!rst || eng_reset) begin
            eng_done <= 1'b0;
            counting <= 1'b0;
        end else if (eng_start) begin
            if (done_lat == 0) eng_done <= 1'b1;
            else if (done_lat > 0) begin
                counting <= 1'b1;
                lat_cnt  <= 1;
            end
        end else if (counting) begin
            if (lat_cnt >= done_lat) begin
                eng_done <= 1'b1;
                counting <= 1'b0;
            end else lat_cnt <= lat_cnt + 1;
        end
    end

    task automatic check(input string name, input int act, input int expv);
        total_cnt++;
        if (act == expv) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", name, act, expv);
    endtask

    // Monitor: every accepted result is compared with the oldest expectation.
    always @(negedge clk) begin
        if (rst && res_valid && res_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("res_class", int'(res_class), e.cls);
                check("res_score", int'($signed(res_score)), e.sc);
                check("res_err", int'(res_err), e.err);
            end
        end
    end

    task automatic push_exp(input int c, input int s, input int e);
        exp_t x;
        x.cls = c; x.sc = s; x.err = e;
        exp_q.push_back(x);
    endtask

    task automatic start_req();
        @(posedge clk); #1 req = 1'b1;
        @(posedge clk); #1 req = 1'b0;
    endtask

    task automatic wait_valid();
        int i;
        for (i = 0; i < 300; i++) begin
            @(negedge clk);
            if (res_valid) break;
        end
        if (i == 300) check("wait_valid_timeout", 0, 1);
    endtask

    task automatic handshake();
        @(posedge clk); #1 res_ready = 1'b1;
        @(posedge clk); #1 res_ready = 1'b0;
    endtask

    task automatic set_all(input int v);
        for (int i = 0; i < 16; i++) scores[i] = v;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        scores = '{3, -5, 12, 7, 12, 0, -64, 1, 2, 63, 0, 0, 0, 0, 0, 0};
        repeat (3) @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_valid", int'(res_valid), 0);
        check("rst_out_idx", int'(out_idx), 0);
        check("rst_class", int'(res_class), 0);
        check("rst_score", int'(res_score), 0);
        check("rst_eng_reset", int'(eng_reset), 0);
        check("rst_err", int'(res_err), 0);
        @(posedge clk); #1 rst = 1'b1;

        // Argmax, done 20 cycles after start
        done_lat = 20;
        push_exp(9, 63, 0);
        start_req();
        wait_valid();
        handshake();

        // Tie at 12 keeps the lower index
        scores[9] = -1;
        push_exp(2, 12, 0);
        start_req();
        wait_valid();
        handshake();

        // Reset mid-scan, then pulse ordering after release
        done_lat = 0;
        start_req();
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (out_idx == 4'd3) break;
        end
        check("scan_reached", int'(out_idx), 3);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("abort_busy", int'(busy), 0);
        check("abort_valid", int'(res_valid), 0);
        check("abort_out_idx", int'(out_idx), 0);
        @(posedge clk); #1 rst = 1'b1; req = 1'b1;
        @(posedge clk); #1 req = 1'b0;
        push_exp(2, 12, 0);
        @(negedge clk);
        check("c1_eng_reset", int'(eng_reset), 1);
        check("c1_eng_start", int'(eng_start), 0);
        @(negedge clk);
        check("c2_eng_reset", int'(eng_reset), 0);
        check("c2_eng_start", int'(eng_start), 1);
        wait_valid();
        handshake();

        // Negatives with backpressure and back-to-back request
        set_all(-64);
        scores[4] = -63;
        done_lat = 3;
        push_exp(4, -63, 0);
        start_req();
        wait_valid();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_valid", int'(res_valid), 1);
            check("bp_class", int'(res_class), 4);
            check("bp_score", int'($signed(res_score)), -63);
            check("bp_no_clear", int'(eng_reset), 0);
        end
        @(posedge clk); #1 req = 1'b1; res_ready = 1'b1;
        @(posedge clk); #1 res_ready = 1'b0;
        push_exp(4, -63, 0);
        @(negedge clk);
        check("b2b_idle_valid", int'(res_valid), 0);
        check("b2b_idle_busy", int'(busy), 0);
        @(posedge clk); #1 req = 1'b0;
        @(negedge clk);
        check("b2b_clear", int'(eng_reset), 1);
        wait_valid();
        handshake();

        // All equal, immediate done: sweep timing
        set_all(5);
        done_lat = 0;
        push_exp(0, 5, 0);
        start_req();
        repeat (3) @(negedge clk);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("sweep_idx", int'(out_idx), k);
            check("sweep_no_valid", int'(res_valid), 0);
        end
        @(negedge clk);
        check("sweep_valid", int'(res_valid), 1);
        handshake();

        // Engine never finishes
        done_lat = -1;
`ifdef DNN_SEQ_TIMEOUT_EN
        push_exp(0, 0, 1);
        start_req();
        wait_valid();
        check("tmo_err", int'(res_err), 1);
        handshake();
        @(negedge clk);
        check("tmo_err_cleared", int'(res_err), 0);
`else
        start_req();
        repeat (200) @(negedge clk);
        check("hang_busy", int'(busy), 1);
        check("hang_no_valid", int'(res_valid), 0);
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
`endif

        repeat (3) @(negedge clk);
        check("sb_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
